// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array controller.
//   state_t   : controller states
//   cnt_width : width of the FEED cycle counter for a given K width and array size
//   feed_len  : number of FEED cycles for a given K and array size (K+2N-2)
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    FEED  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One spare bit above K+2N so the largest K cannot wrap the counter.
  function automatic int cnt_width(input int k_width, input int n);
    return k_width + $clog2(2 * n) + 1;
  endfunction

  function automatic logic [31:0] feed_len(input logic [31:0] k, input int unsigned n);
    return k + 32'(2 * n) - 32'd2;
  endfunction

endpackage

// File: rtl/systolic_skew_buffer.sv
// Triangular delay line: lane i is delayed by i clock cycles, lane 0 passes
// straight through.
//   clk, reset : clock, asynchronous active-high reset (clears all stages)
//   din        : lanes x width input, lane i at din[i*width +: width]
//   dout       : lanes x width output, same packing
module systolic_skew_buffer #(
  parameter int width = 16,
  parameter int lanes = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [lanes*width-1:0]   din,
  output logic [lanes*width-1:0]   dout
);

  for (genvar i = 0; i < lanes; i++) begin : g_lane
    if (i == 0) begin : g_pass
      assign dout[width-1:0] = din[width-1:0];
    end else begin : g_dly
      logic [width-1:0] stage [i];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int s = 0; s < i; s++) stage[s] <= '0;
        end else begin
          stage[0] <= din[i*width +: width];
          for (int s = 1; s < i; s++) stage[s] <= stage[s-1];
        end
      end

      assign dout[i*width +: width] = stage[i-1];
    end
  end

endmodule

// File: rtl/systolic_controller.sv
// Sequencer for one output-stationary matrix multiply C = A*B on an N x N
// systolic MAC array. Clears the accumulators, streams K operand slices from
// the operand buffer, skews them onto the array edges and opens the per-PE
// enable windows, then pulses done once the accumulators hold C.
//
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   start, kLen           : command pulse (accepted only in IDLE), inner dimension K
//   busy, done            : run in progress / one-cycle completion pulse
//   rdEn, rdIdx           : operand-buffer read, data returns one cycle later
//   aCol, bRow            : A[0..N-1][k] and B[k][0..N-1], lane i at [i*dataSize +: dataSize]
//   leftInputs, topInputs : skewed operands for the array's left / top edges
//   clearSignals          : per-PE accumulator clear, PE(i,j) at bit i*N+j
//   enableSignals         : per-PE MAC enable, PE(i,j) at bit i*N+j
//
// state | meaning
// IDLE  | waiting for start
// CLEAR | one cycle: clear all accumulators, issue read of slice 0
// FEED  | K+2N-2 cycles: stream slices, skew edges, drive enable windows
// DONE  | one cycle: done pulse, C valid on the array outputs
module systolic_controller
  import systolic_pkg::*;
#(
  parameter int matrixSize = 8,
  parameter int dataSize   = 16,
  parameter int kWidth     = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [kWidth-1:0]                    kLen,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 rdEn,
  output logic [kWidth-1:0]                    rdIdx,
  input  logic [matrixSize*dataSize-1:0]       aCol,
  input  logic [matrixSize*dataSize-1:0]       bRow,
  output logic [matrixSize*dataSize-1:0]       leftInputs,
  output logic [matrixSize*dataSize-1:0]       topInputs,
  output logic [matrixSize*matrixSize-1:0]     clearSignals,
  output logic [matrixSize*matrixSize-1:0]     enableSignals
);

  localparam int N  = matrixSize;
  localparam int CW = cnt_width(kWidth, matrixSize);

  state_t                 state, state_nxt;
  logic [kWidth-1:0]      k_q;
  logic [CW-1:0]          cnt_q, cnt_nxt, cnt_inc, k_ext, feed_last;
  logic                   feeding, feed_valid;
  logic [N*dataSize-1:0]  a_feed, b_feed;

  assign k_ext     = CW'(k_q);
  assign cnt_inc   = cnt_q + CW'(1);
  assign feed_last = CW'(feed_len(32'(k_q), N) - 32'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      k_q   <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      cnt_q <= cnt_nxt;
      if (state == IDLE && start) k_q <= kLen;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    case (state)
      IDLE:  if (start) state_nxt = CLEAR;
      CLEAR: begin
        cnt_nxt   = '0;
        state_nxt = (k_q != '0) ? FEED : DONE;
      end
      FEED: begin
        if (cnt_q == feed_last) state_nxt = DONE;
        else                    cnt_nxt   = cnt_inc;
      end
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign feeding      = (state == FEED);
  // Buffer data is only meaningful for the K cycles after the reads; zero
  // it otherwise so the skew lines flush clean.
  assign feed_valid   = feeding && (cnt_q < k_ext);
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign clearSignals = {(N*N){state == CLEAR}};

  always_comb begin
    rdEn  = 1'b0;
    rdIdx = '0;
    if (state == CLEAR && k_q != '0) begin
      rdEn = 1'b1;
    end else if (feeding && cnt_inc < k_ext) begin
      rdEn  = 1'b1;
      rdIdx = cnt_inc[kWidth-1:0];
    end
  end

  // PE(i,j) window is i+j <= c <= i+j+K-1; cnt_inc > diag is c >= diag
  // without a constant-true compare on the (0,0) corner.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      localparam logic [CW-1:0] DIAG = CW'(i + j);
      assign enableSignals[i*N+j] = feeding && (cnt_inc > DIAG) && (cnt_q < DIAG + k_ext);
    end
  end

  assign a_feed = feed_valid ? aCol : '0;
  assign b_feed = feed_valid ? bRow : '0;

  systolic_skew_buffer #(.width(dataSize), .lanes(N)) u_skew_a (
    .clk  (clk),
    .reset(reset),
    .din  (a_feed),
    .dout (leftInputs)
  );

  systolic_skew_buffer #(.width(dataSize), .lanes(N)) u_skew_b (
    .clk  (clk),
    .reset(reset),
    .din  (b_feed),
    .dout (topInputs)
  );

endmodule

// File: tb/tb_systolic_controller.sv
module tb_systolic_controller;

  localparam int N    = 4;
  localparam int D    = 16;
  localparam int KW   = 16;
  localparam int MAXK = 16;

  logic              clk = 1'b0;
  logic              reset, start;
  logic [KW-1:0]     kLen;
  logic              busy, done, rdEn;
  logic [KW-1:0]     rdIdx;
  logic [N*D-1:0]    aCol, bRow, leftInputs, topInputs;
  logic [N*N-1:0]    clearSignals, enableSignals;

  always #5 clk = ~clk;

  systolic_controller #(.matrixSize(N), .dataSize(D), .kWidth(KW)) dut (
    .clk(clk), .reset(reset), .start(start), .kLen(kLen),
    .busy(busy), .done(done), .rdEn(rdEn), .rdIdx(rdIdx),
    .aCol(aCol), .bRow(bRow),
    .leftInputs(leftInputs), .topInputs(topInputs),
    .clearSignals(clearSignals), .enableSignals(enableSignals)
  );

  int total = 0;
  int bad   = 0;

  logic signed [D-1:0] amat [N][MAXK];
  logic signed [D-1:0] bmat [MAXK][N];

  // Operand buffer: one-cycle read latency, garbage when not reading.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rdEn && rdIdx < MAXK) begin
        aCol[i*D +: D] <= amat[i][rdIdx];
        bRow[i*D +: D] <= bmat[rdIdx][i];
      end else begin
        aCol[i*D +: D] <= D'($urandom);
        bRow[i*D +: D] <= D'($urandom);
      end
    end
  end

  // Output-stationary MAC array: operands move right / down one PE per cycle.
  longint              acc    [N][N];
  logic signed [D-1:0] a_pipe [N][N];
  logic signed [D-1:0] b_pipe [N][N];

  function automatic logic signed [D-1:0] a_at(input int i, input int j);
    return (j == 0) ? leftInputs[i*D +: D] : a_pipe[i][j-1];
  endfunction
  function automatic logic signed [D-1:0] b_at(input int i, input int j);
    return (i == 0) ? topInputs[j*D +: D] : b_pipe[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        a_pipe[i][j] <= a_at(i, j);
        b_pipe[i][j] <= b_at(i, j);
        if (clearSignals[i*N+j])
          acc[i][j] <= 0;
        else if (enableSignals[i*N+j])
          acc[i][j] <= acc[i][j] + longint'(a_at(i, j)) * longint'(b_at(i, j));
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int k;
    int pat;       // 0: A=I, B=4k+j+1   1: A=i+1, B=-(j+1)   2: random
    int glitch;    // cycle in which an extra start is pulsed (-1 none)
    int abort;     // cycle in which reset is asserted (-1 none)
    int exp_done;  // expected done cycle (-1 none)
  } run_t;

  task automatic load(input int pat);
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < MAXK; k++) begin
        case (pat)
          0: begin amat[i][k] = (i == k) ? D'(1) : D'(0); bmat[k][i] = D'(4*k + i + 1); end
          1: begin amat[i][k] = D'(i + 1); bmat[k][i] = D'(-(i + 1)); end
          default: begin amat[i][k] = D'($urandom); bmat[k][i] = D'($urandom); end
        endcase
      end
    end
  endtask

  // Expected outputs n cycles after the start-sampling edge, from the
  // cycle-level timing rules: CLEAR at 1, FEED c = n-2, done at dc.
  task automatic sample(input int n, input int k, input int dc);
    logic [N*D-1:0] el, et;
    logic [N*N-1:0] ee;
    int c;
    bit feed, exp_rd;
    el = '0; et = '0; ee = '0;
    c = n - 2;
    feed = (k > 0) && (n >= 2) && (n <= k + 2*N - 1);
    exp_rd = (n >= 1) && (n <= k);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++)
        if (feed && c >= i + j && c <= i + j + k - 1) ee[i*N+j] = 1'b1;
      if (feed && c - i >= 0 && c - i < k) begin
        el[i*D +: D] = amat[i][c-i];
        et[i*D +: D] = bmat[c-i][i];
      end
    end
    chk($sformatf("busy@%0d", n),   64'(busy),  64'((n >= 1) && (dc < 0 || n <= dc)));
    chk($sformatf("done@%0d", n),   64'(done),  64'(n == dc));
    chk($sformatf("clear@%0d", n),  64'(clearSignals), (n == 1) ? 64'({(N*N){1'b1}}) : 64'(0));
    chk($sformatf("rdEn@%0d", n),   64'(rdEn),  64'(exp_rd));
    if (exp_rd) chk($sformatf("rdIdx@%0d", n), 64'(rdIdx), 64'(n - 1));
    chk($sformatf("enable@%0d", n), 64'(enableSignals), 64'(ee));
    chk($sformatf("left@%0d", n),   64'(leftInputs), 64'(el));
    chk($sformatf("top@%0d", n),    64'(topInputs),  64'(et));
  endtask

  task automatic check_c(input run_t r);
    longint s;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < r.k; k++) s += longint'(amat[i][k]) * longint'(bmat[k][j]);
        chk($sformatf("C[%0d][%0d] k=%0d", i, j, r.k), 64'(acc[i][j]), 64'(s));
        if (r.pat == 0) chk($sformatf("C_eq_B[%0d][%0d]", i, j), 64'(acc[i][j]), 64'(longint'(bmat[i][j])));
      end
    end
    if (r.pat == 1 && r.k == 1) chk("C[3][3]_neg16", 64'(acc[3][3]), 64'(-64'sd16));
  endtask

  task automatic run(input run_t r);
    int last;
    load(r.pat);
    last = (r.abort > 0) ? r.abort : r.exp_done + 3;
    @(negedge clk);
    start = 1'b1;
    kLen  = KW'(r.k);
    for (int n = 1; n <= last; n++) begin
      @(negedge clk);
      if (n == 1) begin start = 1'b0; kLen = KW'($urandom); end
      if (n == r.glitch + 1) start = 1'b0;
      sample(n, r.k, r.exp_done);
      if (n == r.exp_done) check_c(r);
      if (n == r.glitch) begin start = 1'b1; kLen = KW'($urandom_range(1, 9)); end
      if (n == r.abort) begin
        reset = 1'b1;
        #1;
        chk("abort_ctrl", 64'({busy, done, rdEn, rdIdx, clearSignals, enableSignals}), 64'(0));
        chk("abort_left", 64'(leftInputs), 64'(0));
        chk("abort_top",  64'(topInputs),  64'(0));
        @(negedge clk);
        reset = 1'b0;
        for (int m = 0; m < 4; m++) begin
          @(negedge clk);
          chk($sformatf("abort_quiet%0d", m), 64'({busy, done, rdEn}), 64'(0));
        end
      end
    end
  endtask

  run_t tbl [7];

  initial begin
    tbl[0] = '{k: 4, pat: 0, glitch: -1, abort: -1, exp_done: 12};
    tbl[1] = '{k: 1, pat: 1, glitch: -1, abort: -1, exp_done: 9};
    tbl[2] = '{k: 0, pat: 2, glitch: -1, abort: -1, exp_done: 2};
    tbl[3] = '{k: 3, pat: 2, glitch: 5,  abort: -1, exp_done: 11};
    tbl[4] = '{k: 8, pat: 2, glitch: -1, abort: 6,  exp_done: -1};
    tbl[5] = '{k: 2, pat: 2, glitch: -1, abort: -1, exp_done: 10};
    tbl[6] = '{k: 5, pat: 2, glitch: -1, abort: -1, exp_done: 13};

    reset = 1'b1;
    start = 1'b0;
    kLen  = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 64'({busy, done, rdEn, rdIdx, clearSignals, enableSignals}), 64'(0));
    chk("reset_left", 64'(leftInputs), 64'(0));
    chk("reset_top",  64'(topInputs),  64'(0));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 7; t++) run(tbl[t]);

    for (int t = 0; t < 4; t++) begin
      run_t r;
      r.k        = $urandom_range(1, 7);
      r.pat      = 2;
      r.glitch   = -1;
      r.abort    = -1;
      r.exp_done = r.k + 2*N;
      run(r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
